button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20000, consecutive stable cycles (10 ms at 2 MHz) required to accept a level change.
REQ-002 Parameter REPEAT_DELAY, default 1000000, hold cycles (0.5 s) before the first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 200000, cycles (0.1 s) between subsequent auto-repeat pulses.
REQ-004 clk_2MHz  input  1  sole clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 s1_async..s5_async  input  1 each  raw push-switch levels, asynchronous, active-high, bouncing.
REQ-007 s1_pulse..s5_pulse  output  1 each  one-cycle press (and repeat) strobe per channel, registered.
REQ-008 s1_level..s5_level  output  1 each  debounced, synchronized level per channel, registered.

Function
REQ-009 Each channel SHALL be fully independent; simultaneous activity on any channels SHALL not interact.
REQ-010 Each raw input SHALL pass through a two-flop synchronizer before any other use.
REQ-011 Per channel, a counter of width ceil(log2(DEBOUNCE_CYCLES+1)) SHALL count cycles in which the synchronized input differs from sN_level, clearing to 0 on any cycle they match.
REQ-012 sN_level SHALL toggle on the edge at which the counter would reach DEBOUNCE_CYCLES; the counter clears in that same edge.
REQ-013 Latency: a clean step on sN_async sampled at edge k SHALL change sN_level at edge k+2+DEBOUNCE_CYCLES.
REQ-014 Glitches or bounces shorter than DEBOUNCE_CYCLES cycles SHALL leave sN_level unchanged.
REQ-015 Per-channel FSM states: IDLE (level 0), HELD (level 1, waiting REPEAT_DELAY), REPEAT (level 1, periodic).
REQ-016 IDLE -> HELD when sN_level rises; sN_pulse SHALL be 1 for exactly the cycle in which sN_level first reads 1.
REQ-017 HELD -> REPEAT after REPEAT_DELAY cycles with level still 1, emitting one pulse on entry.
REQ-018 In REPEAT, one pulse SHALL be emitted every REPEAT_PERIOD cycles while level stays 1.
REQ-019 Any state -> IDLE in the cycle level falls; no pulse SHALL be generated on release.
REQ-020 Hold/repeat counters SHALL saturate-free wrap-guard: counter resets on every state transition, never overflows.
REQ-021 sN_pulse SHALL never be high on two consecutive cycles.

Reset
REQ-022 On reset, synchronizer flops, debounce counters, hold counters, sN_level and sN_pulse SHALL be 0 and every FSM IDLE at the next edge.
REQ-023 Reset asserted mid-press SHALL drop sN_level and sN_pulse to 0; a still-held switch after reset SHALL be re-debounced and produce a fresh press pulse.
REQ-024 Reset SHALL take priority over every other event in the same cycle.

Configuration
REQ-025 Macro BUTTON_AUTOREPEAT_EN, when defined, SHALL compile in HELD/REPEAT behaviour (REQ-017, REQ-018).
REQ-026 Without BUTTON_AUTOREPEAT_EN, the FSM SHALL reduce to IDLE/HELD with no hold timers, giving exactly one pulse per debounced press regardless of hold length.

Verification (sim parameters DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean press on s1_async sampled at edge 0 -> s1_level=1 and s1_pulse=1 at edge 6 only; release -> s1_level=0 at edge 6 after release, no pulse.
REQ-028 s2_async bounce pattern 1,0,1,1,0,1 then held -> no level change until 4 stable cycles after last bounce; exactly one s2_pulse.
REQ-029 BUTTON_AUTOREPEAT_EN defined, s3 held 30 cycles past level rise -> pulses at level-rise offsets 0, 10, 13, 16, 19, 22, 25, 28; none after release.
REQ-030 BUTTON_AUTOREPEAT_EN undefined, same stimulus -> single pulse at offset 0.
REQ-031 s4 and s5 pressed in the same cycle -> s4_pulse and s5_pulse asserted in the same cycle, both levels 1.
REQ-032 reset pulsed while s1 held in REPEAT -> all outputs 0 next edge; s1 pulse again 6 cycles after reset deasserts.

Source files
------------

// File: rtl/button_conditioner_if.sv
// button_conditioner_if -- groups the five push-switch channels.
//   sN_async : raw, asynchronous, bouncing switch level (source -> conditioner)
//   sN_pulse : one-cycle press / auto-repeat strobe     (conditioner -> sink)
//   sN_level : debounced, synchronized switch level      (conditioner -> sink)
// master: the side that owns the switches and consumes the conditioned outputs.
// slave : the conditioner itself.
interface button_conditioner_if;
  logic s1_async, s2_async, s3_async, s4_async, s5_async;
  logic s1_pulse, s2_pulse, s3_pulse, s4_pulse, s5_pulse;
  logic s1_level, s2_level, s3_level, s4_level, s5_level;

  modport master (
    output s1_async, s2_async, s3_async, s4_async, s5_async,
    input  s1_pulse, s2_pulse, s3_pulse, s4_pulse, s5_pulse,
    input  s1_level, s2_level, s3_level, s4_level, s5_level
  );

  modport slave (
    input  s1_async, s2_async, s3_async, s4_async, s5_async,
    output s1_pulse, s2_pulse, s3_pulse, s4_pulse, s5_pulse,
    output s1_level, s2_level, s3_level, s4_level, s5_level
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner -- five independent push-switch conditioners.
// Each channel: two-flop synchronizer -> debounce counter -> press FSM.
// Ports:
//   clk_2MHz : sole clock, rising edge
//   reset    : synchronous, active-high
//   btn      : button_conditioner_if.slave (sN_async in, sN_pulse/sN_level out)
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a level change
//   REPEAT_DELAY    : hold cycles from press to first auto-repeat pulse
//   REPEAT_PERIOD   : cycles between subsequent auto-repeat pulses
// Build option: define BUTTON_AUTOREPEAT_EN to compile in HELD/REPEAT
// auto-repeat; otherwise one pulse per debounced press.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 1000000,
  parameter int unsigned REPEAT_PERIOD   = 200000
) (
  input  logic                 clk_2MHz,
  input  logic                 reset,
  button_conditioner_if.slave  btn
);

  localparam int unsigned NCH  = 5;
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;
`else
  typedef enum logic [0:0] {IDLE, HELD} state_t;
`endif

  // A period below 2 would allow back-to-back strobes.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES>=1, REPEAT_DELAY>=1, REPEAT_PERIOD>=2 required");
  end

  logic [NCH-1:0] raw;
  logic [NCH-1:0] sync1;
  logic [NCH-1:0] sync2;
  logic [NCH-1:0] level_q;
  logic [NCH-1:0] pulse_q;

  assign raw = {btn.s5_async, btn.s4_async, btn.s3_async, btn.s2_async, btn.s1_async};

  assign btn.s1_level = level_q[0];
  assign btn.s2_level = level_q[1];
  assign btn.s3_level = level_q[2];
  assign btn.s4_level = level_q[3];
  assign btn.s5_level = level_q[4];
  assign btn.s1_pulse = pulse_q[0];
  assign btn.s2_pulse = pulse_q[1];
  assign btn.s3_pulse = pulse_q[2];
  assign btn.s4_pulse = pulse_q[3];
  assign btn.s5_pulse = pulse_q[4];

  always_ff @(posedge clk_2MHz) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic            level_r;
    logic            level_d;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_d;
    state_t          state;
    state_t          state_d;
    logic            pulse_r;
    logic            pulse_d;

    // Counter holds the number of mismatching cycles seen so far; the next
    // mismatch after it reaches DEBOUNCE_CYCLES flips the level, which puts
    // the level change at edge k+2+DEBOUNCE_CYCLES for a step sampled at k.
    always_comb begin
      level_d  = level_r;
      db_cnt_d = '0;
      if (sync2[g] != level_r) begin
        if (db_cnt == DB_W'(DEBOUNCE_CYCLES)) begin
          level_d  = ~level_r;
          db_cnt_d = '0;
        end else begin
          db_cnt_d = db_cnt + 1'b1;
        end
      end
    end

    always_ff @(posedge clk_2MHz) begin
      if (reset) begin
        level_r <= 1'b0;
        db_cnt  <= '0;
      end else begin
        level_r <= level_d;
        db_cnt  <= db_cnt_d;
      end
    end

    // The FSM looks at level_d so the registered pulse lands in the same
    // cycle that sN_level first reads 1.
`ifdef BUTTON_AUTOREPEAT_EN
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_cnt_d;

    always_comb begin
      state_d    = state;
      hold_cnt_d = hold_cnt;
      pulse_d    = 1'b0;
      case (state)
        IDLE: begin
          hold_cnt_d = '0;
          if (level_d) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end
        end
        HELD: begin
          if (!level_d) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt == HOLD_W'(REPEAT_DELAY - 1)) begin
            state_d    = REPEAT;
            pulse_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!level_d) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else if (hold_cnt == HOLD_W'(REPEAT_PERIOD - 1)) begin
            pulse_d    = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt + 1'b1;
          end
        end
        default: begin
          state_d    = IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end

    always_ff @(posedge clk_2MHz) begin
      if (reset) begin
        state    <= IDLE;
        hold_cnt <= '0;
        pulse_r  <= 1'b0;
      end else begin
        state    <= state_d;
        hold_cnt <= hold_cnt_d;
        pulse_r  <= pulse_d;
      end
    end
`else
    always_comb begin
      state_d = state;
      pulse_d = 1'b0;
      case (state)
        IDLE: begin
          if (level_d) begin
            state_d = HELD;
            pulse_d = 1'b1;
          end
        end
        HELD: begin
          if (!level_d) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk_2MHz) begin
      if (reset) begin
        state   <= IDLE;
        pulse_r <= 1'b0;
      end else begin
        state   <= state_d;
        pulse_r <= pulse_d;
      end
    end
`endif

    assign level_q[g] = level_r;
    assign pulse_q[g] = pulse_r;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. A window-based reference model predicts levels and pulses
// for every edge; directed scenarios pin the model with literal edge offsets,
// followed by randomized bouncing with occasional resets.
module tb_button_conditioner;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int NCH  = 5;
  localparam int MAXE = 8192;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk_2MHz = 1'b0;
  logic reset    = 1'b1;
  logic [NCH-1:0] drv = '0;
  logic [NCH-1:0] lvl_o, pls_o;

  always #5 clk_2MHz = ~clk_2MHz;

  button_conditioner_if btn_if();

  assign btn_if.s1_async = drv[0];
  assign btn_if.s2_async = drv[1];
  assign btn_if.s3_async = drv[2];
  assign btn_if.s4_async = drv[3];
  assign btn_if.s5_async = drv[4];
  assign lvl_o = {btn_if.s5_level, btn_if.s4_level, btn_if.s3_level, btn_if.s2_level, btn_if.s1_level};
  assign pls_o = {btn_if.s5_pulse, btn_if.s4_pulse, btn_if.s3_pulse, btn_if.s2_pulse, btn_if.s1_pulse};

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk_2MHz(clk_2MHz),
    .reset(reset),
    .btn(btn_if)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit valid = 1'b0;
  bit done  = 1'b0;

  // ---------------- reference model ----------------
  logic [NCH-1:0] raw_h [MAXE];
  logic [NCH-1:0] s2_h  [MAXE];
  bit             rst_h [MAXE];
  bit m_lvl [NCH];
  bit m_pls [NCH];
  int m_rise[NCH];
  int m_last[NCH];

  initial begin
    for (int c = 0; c < NCH; c++) begin
      m_lvl[c] = 1'b0; m_pls[c] = 1'b0; m_rise[c] = -1; m_last[c] = -1;
    end
  end

  // Level flips at edge e when the synchronized input has disagreed with it
  // on D+1 consecutive edges e-D..e, none at or before the last flip/reset.
  // Pulses: the rise edge, then (auto-repeat) offsets RD, RD+RP, RD+2RP, ...
  always @(posedge clk_2MHz) begin : model
    int e;
    bit s2, tog, prev;
    e = cyc;
    if (e < MAXE) begin
      raw_h[e] = drv;
      rst_h[e] = reset;
      for (int c = 0; c < NCH; c++) begin
        if (reset) begin
          m_lvl[c] = 1'b0; m_pls[c] = 1'b0; m_rise[c] = -1; m_last[c] = e;
          s2_h[e][c] = 1'b0;
        end else begin
          s2 = (e >= 2 && !rst_h[e-1] && !rst_h[e-2]) ? raw_h[e-2][c] : 1'b0;
          s2_h[e][c] = s2;
          tog = 1'b1;
          for (int i = e - D; i <= e; i++) begin
            if (i < 0 || i <= m_last[c] || s2_h[i][c] == m_lvl[c]) tog = 1'b0;
          end
          prev = m_lvl[c];
          if (tog) begin
            m_lvl[c]  = ~m_lvl[c];
            m_last[c] = e;
          end
          if (m_lvl[c] && !prev) begin
            m_pls[c]  = 1'b1;
            m_rise[c] = e;
          end else if (AR && m_lvl[c] && (e - m_rise[c]) >= RD && ((e - m_rise[c] - RD) % RP) == 0) begin
            m_pls[c] = 1'b1;
          end else begin
            m_pls[c] = 1'b0;
          end
          if (!m_lvl[c]) m_rise[c] = -1;
        end
      end
      if (reset) valid = 1'b1;
    end
    cyc = cyc + 1;
  end

  // ---------------- event logs of DUT outputs ----------------
  typedef struct { int ch; int ev; } ev_t;
  ev_t pq[$];
  ev_t lq[$];
  logic [NCH-1:0] prev_lvl = '0;

  always @(negedge clk_2MHz) begin : compare
    ev_t x;
    if (valid && !done && cyc <= MAXE) begin
      for (int c = 0; c < NCH; c++) begin
        total++;
        if (lvl_o[c] !== m_lvl[c]) begin
          bad++;
          $display("FAIL level s%0d edge %0d: got %b want %b", c + 1, cyc - 1, lvl_o[c], m_lvl[c]);
        end
        total++;
        if (pls_o[c] !== m_pls[c]) begin
          bad++;
          $display("FAIL pulse s%0d edge %0d: got %b want %b", c + 1, cyc - 1, pls_o[c], m_pls[c]);
        end
        x.ch = c; x.ev = cyc - 1;
        if (pls_o[c] === 1'b1) pq.push_back(x);
        if (lvl_o[c] !== prev_lvl[c]) lq.push_back(x);
      end
      prev_lvl = lvl_o;
    end
  end

  function automatic int n_events(input bit use_p, input int c, input int from);
    int n = 0;
    if (use_p) begin
      foreach (pq[i]) if (pq[i].ch == c && pq[i].ev >= from) n++;
    end else begin
      foreach (lq[i]) if (lq[i].ch == c && lq[i].ev >= from) n++;
    end
    return n;
  endfunction

  function automatic int nth_event(input bit use_p, input int c, input int from, input int n);
    int k = 0;
    if (use_p) begin
      foreach (pq[i]) if (pq[i].ch == c && pq[i].ev >= from) begin
        if (k == n) return pq[i].ev;
        k++;
      end
    end else begin
      foreach (lq[i]) if (lq[i].ch == c && lq[i].ev >= from) begin
        if (k == n) return lq[i].ev;
        k++;
      end
    end
    return -1;
  endfunction

  task automatic check_int(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_2MHz);
    #1;
  endtask

  initial begin : watchdog
    #(20 * MAXE * 10);
    $display("FAIL watchdog: time limit reached before end of stimulus");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int e0, e1, b, s, r, p, q, rr;
    int exp3 [8];
    logic [5:0] bounce;
    exp3 = '{0, 10, 13, 16, 19, 22, 25, 28};

    drv   = '0;
    reset = 1'b1;
    tick(3);
    check_int("reset_level", int'(lvl_o), 0);
    check_int("reset_pulse", int'(pls_o), 0);
    reset = 1'b0;
    tick(5);

    // Clean press/release on s1: level and pulse 6 edges after the sample.
    e0 = cyc; drv[0] = 1'b1; tick(8);
    e1 = cyc; drv[0] = 1'b0; tick(14);
    check_int("s1_pulse_count", n_events(1, 0, e0), 1);
    check_int("s1_pulse_edge", nth_event(1, 0, e0, 0), e0 + 6);
    check_int("s1_rise_edge", nth_event(0, 0, e0, 0), e0 + 6);
    check_int("s1_fall_edge", nth_event(0, 0, e0, 1), e1 + 6);

    // s2 bounce 1,0,1,1,0,1 then held: last 0 sampled at b+4.
    b = cyc;
    bounce = 6'b101101;
    for (int i = 0; i < 6; i++) begin
      drv[1] = bounce[5 - i];
      tick(1);
    end
    tick(7);
    drv[1] = 1'b0;
    tick(14);
    check_int("s2_rise_edge", nth_event(0, 1, b, 0), b + 11);
    check_int("s2_level_changes", n_events(0, 1, b), 2);
    check_int("s2_pulse_count", n_events(1, 1, b), 1);
    check_int("s2_pulse_edge", nth_event(1, 1, b, 0), b + 11);

    // s3 held 30 cycles past its level rise.
    s = cyc; drv[2] = 1'b1; r = s + 6;
    tick(30);
    drv[2] = 1'b0;
    tick(14);
    check_int("s3_fall_edge", nth_event(0, 2, s, 1), r + 30);
    check_int("s3_pulse_count", n_events(1, 2, s), AR ? 8 : 1);
    for (int i = 0; i < (AR ? 8 : 1); i++)
      check_int($sformatf("s3_pulse_offset%0d", i), nth_event(1, 2, s, i) - r, exp3[i]);

    // s4 and s5 pressed together.
    p = cyc; drv[3] = 1'b1; drv[4] = 1'b1;
    tick(6);
    drv[3] = 1'b0; drv[4] = 1'b0;
    tick(14);
    check_int("s4_pulse_edge", nth_event(1, 3, p, 0), p + 6);
    check_int("s5_pulse_edge", nth_event(1, 4, p, 0), p + 6);
    check_int("s4_pulse_count", n_events(1, 3, p), 1);
    check_int("s5_pulse_count", n_events(1, 4, p), 1);
    check_int("s4_rise_edge", nth_event(0, 3, p, 0), p + 6);
    check_int("s5_rise_edge", nth_event(0, 4, p, 0), p + 6);

    // Reset while s1 is in auto-repeat; switch stays held throughout.
    q = cyc; drv[0] = 1'b1;
    tick(20);
    rr = cyc; reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check_int("midpress_reset_level", int'(lvl_o), 0);
    check_int("midpress_reset_pulse", int'(pls_o), 0);
    tick(12);
    check_int("s1_prereset_pulses", n_events(1, 0, q) - n_events(1, 0, rr), AR ? 3 : 1);
    check_int("s1_post_reset_pulse", nth_event(1, 0, rr, 0), rr + 7);
    drv[0] = 1'b0;
    tick(14);

    // Randomized bouncing on all channels with occasional resets.
    for (int t = 0; t < 2000; t++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 11) == 0) drv[c] = ~drv[c];
      reset = ($urandom_range(0, 599) == 0);
      tick(1);
    end
    reset = 1'b0;
    drv   = '0;
    tick(30);

    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
